// File: rtl/umi_unpack_pipe_pkg.sv
// Shared UMI command layout, opcode constants, tracker states and the
// per-beat metadata record carried alongside each forwarded transaction.
package umi_pkg;

    localparam logic [4:0] UMI_INVALID    = 5'h00;
    localparam logic [4:0] UMI_RESP_LINK  = 5'h0E;
    localparam logic [4:0] UMI_REQ_ERROR  = 5'h0F;
    localparam logic [4:0] UMI_REQ_LINK   = 5'h0F;
    localparam logic [2:0] UMI_SIZE_ERROR = 3'd0;
    localparam logic [2:0] UMI_SIZE_LINK  = 3'd1;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_W   = 5;
    localparam int SIZE_LSB   = 5;
    localparam int SIZE_W     = 3;
    localparam int LEN_LSB    = 8;
    localparam int LEN_W      = 8;
    localparam int QOS_LSB    = 16;
    localparam int QOS_W      = 4;
    localparam int PROT_LSB   = 20;
    localparam int PROT_W     = 2;
    localparam int EOM_BIT    = 22;
    localparam int EOF_BIT    = 23;
    localparam int EX_BIT     = 24;
    localparam int ERR_LSB    = 25;
    localparam int ERR_W      = 2;
    localparam int HOSTID_LSB = 27;
    localparam int HOSTID_W   = 5;

    typedef enum logic {
        TRK_IDLE,
        TRK_MSG
    } trk_state_e;

    typedef struct packed {
        logic [18:0] user;
        logic [1:0]  err;
        logic        request;
        logic        response;
        logic        invalid;
        logic        error;
        logic        link;
        logic        link_resp;
        logic [15:0] bytes;
        logic        som;
        logic [7:0]  beat;
        logic        mismatch;
    } umi_meta_t;

endpackage

// File: rtl/umi_unpack_pipe_if.sv
// UMI transaction port: valid/ready handshake plus cmd/dstaddr/srcaddr/data.
interface umi_unpack_pipe_if #(
    parameter int CW = 32,
    parameter int AW = 64,
    parameter int DW = 256
) ();
    logic          valid;
    logic          ready;
    logic [CW-1:0] cmd;
    logic [AW-1:0] dstaddr;
    logic [AW-1:0] srcaddr;
    logic [DW-1:0] data;

    modport master (output valid, cmd, dstaddr, srcaddr, data, input ready);
    modport slave  (input valid, cmd, dstaddr, srcaddr, data, output ready);
endinterface

// File: rtl/umi_unpack_pipe_skid.sv
// Two-entry skid buffer (output register + one skid slot) with a registered
// input ready, so full throughput is kept without a combinational ready path.
module umi_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [W-1:0] i_in_data,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [W-1:0] o_out_data
);
    logic         r_out_valid;
    logic         r_skid_valid;
    logic         r_in_ready;
    logic [W-1:0] r_out_data;
    logic [W-1:0] r_skid_data;
    logic         w_accept;
    logic         w_load;
    logic         w_skid_nxt;

    assign w_accept   = i_in_valid && r_in_ready;
    assign w_load     = !r_out_valid || i_out_ready;
    assign w_skid_nxt = w_load ? 1'b0 : (r_skid_valid || w_accept);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b0;
            // NOTE: payload registers are reset too so every field output reads 0 in reset.
            r_out_data   <= '0;
            r_skid_data  <= '0;
        end else begin
            if (w_load) begin
                if (r_skid_valid) begin
                    r_out_data   <= r_skid_data;
                    r_out_valid  <= 1'b1;
                    r_skid_valid <= 1'b0;
                end else begin
                    r_out_valid <= w_accept;
                    if (w_accept) r_out_data <= i_in_data;
                end
            end else if (w_accept) begin
                r_skid_data  <= i_in_data;
                r_skid_valid <= 1'b1;
            end
            r_in_ready <= !w_skid_nxt;
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
endmodule

// File: rtl/umi_unpack_pipe.sv
// Registered UMI command unpacker with message tracker and sticky status.
// Optional per-class transfer counters are enabled by defining UMI_UNPACK_STATS_EN.
module umi_unpack_pipe
    import umi_pkg::*;
#(
    parameter int CW = 32,
    parameter int AW = 64,
    parameter int DW = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    umi_unpack_pipe_if.slave  umi_in,
    umi_unpack_pipe_if.master umi_out,
    output logic [4:0]        out_opcode,
    output logic [2:0]        out_size,
    output logic [7:0]        out_len,
    output logic [3:0]        out_qos,
    output logic [1:0]        out_prot,
    output logic              out_eom,
    output logic              out_eof,
    output logic              out_ex,
    output logic [4:0]        out_hostid,
    output logic [18:0]       out_user,
    output logic [1:0]        out_err,
    output logic              out_request,
    output logic              out_response,
    output logic              out_invalid,
    output logic              out_error,
    output logic              out_link,
    output logic              out_link_resp,
    output logic [15:0]       out_bytes,
    output logic              out_som,
    output logic [7:0]        out_beat,
    output logic              out_mismatch,
    output logic              sticky_mismatch,
    output logic              sticky_invalid
`ifdef UMI_UNPACK_STATS_EN
    ,
    output logic [15:0]       stat_req,
    output logic [15:0]       stat_resp,
    output logic [15:0]       stat_err
`endif
);
    localparam int MW = $bits(umi_meta_t);
    localparam int PW = MW + CW + 2 * AW + DW;

    logic [CW-1:0]  w_cmd;
    logic [4:0]     w_opcode;
    logic [2:0]     w_size;
    logic [7:0]     w_len;
    logic [4:0]     w_hostid;
    logic           w_eom;
    logic           w_accept;
    umi_meta_t      w_meta;
    umi_meta_t      w_out_meta;
    logic [PW-1:0]  w_skid_in;
    logic [PW-1:0]  w_skid_out;
    logic [CW-1:0]  w_out_cmd;

    trk_state_e     r_state;
    trk_state_e     w_state_nxt;
    logic [7:0]     r_beat;
    logic [4:0]     r_opcode;
    logic [4:0]     r_hostid;
    logic           w_latch;
    logic           r_sticky_mismatch;
    logic           r_sticky_invalid;

    assign w_cmd    = umi_in.cmd;
    assign w_opcode = w_cmd[OPCODE_LSB +: OPCODE_W];
    assign w_size   = w_cmd[SIZE_LSB +: SIZE_W];
    assign w_len    = w_cmd[LEN_LSB +: LEN_W];
    assign w_hostid = w_cmd[HOSTID_LSB +: HOSTID_W];
    assign w_eom    = w_cmd[EOM_BIT];
    assign w_accept = umi_in.valid && umi_in.ready;

    // Decode and tracker results are computed at the input and ride the skid with the beat.
    always_comb begin
        w_meta           = '0;
        w_latch          = 1'b0;
        w_state_nxt      = r_state;
        w_meta.invalid   = (w_opcode == UMI_INVALID);
        w_meta.request   = w_opcode[0];
        w_meta.response  = !w_opcode[0] && !w_meta.invalid;
        w_meta.error     = (w_opcode == UMI_REQ_ERROR) && (w_size == UMI_SIZE_ERROR);
        w_meta.link      = (w_opcode == UMI_REQ_LINK) && (w_size == UMI_SIZE_LINK);
        w_meta.link_resp = (w_opcode == UMI_RESP_LINK);

        if (w_meta.link)           w_meta.user = w_cmd[26:8];
        else if (w_meta.link_resp) w_meta.user = {2'b0, w_cmd[24:8]};
        else if (w_meta.error)     w_meta.user = {8'h0, w_cmd[24:22], w_cmd[15:8]};
        else if (w_meta.request)   w_meta.user = {17'h0, w_cmd[26:25]};

        if (w_meta.response || w_meta.error) w_meta.err = w_cmd[ERR_LSB +: ERR_W];
        if (!(w_meta.invalid || w_meta.error || w_meta.link || w_meta.link_resp))
            w_meta.bytes = ({8'd0, w_len} + 16'd1) << w_size;

        if (!w_meta.invalid) begin
            case (r_state)
                TRK_IDLE: begin
                    w_meta.som = 1'b1;
                    w_latch    = 1'b1;
                    if (w_accept && !w_eom) w_state_nxt = TRK_MSG;
                end
                TRK_MSG: begin
                    w_meta.beat     = (r_beat == 8'hFF) ? 8'hFF : r_beat + 8'd1;
                    w_meta.mismatch = (w_opcode != r_opcode) || (w_hostid != r_hostid);
                    if (w_accept && w_eom) w_state_nxt = TRK_IDLE;
                end
                default: w_state_nxt = TRK_IDLE;
            endcase
        end
        if (clear) w_state_nxt = TRK_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= TRK_IDLE;
            r_beat   <= '0;
            r_opcode <= '0;
            r_hostid <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept && !w_meta.invalid) begin
                r_beat <= w_meta.beat;
                if (w_latch) begin
                    r_opcode <= w_opcode;
                    r_hostid <= w_hostid;
                end
            end
        end
    end

    // Set events are applied after clear so a coincident set wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sticky_mismatch <= 1'b0;
            r_sticky_invalid  <= 1'b0;
        end else begin
            if (clear) begin
                r_sticky_mismatch <= 1'b0;
                r_sticky_invalid  <= 1'b0;
            end
            if (w_accept && w_meta.mismatch) r_sticky_mismatch <= 1'b1;
            if (w_accept && w_meta.invalid)  r_sticky_invalid  <= 1'b1;
        end
    end

    assign w_skid_in = {w_meta, w_cmd, umi_in.dstaddr, umi_in.srcaddr, umi_in.data};

    umi_skid #(.W(PW)) u_skid (
        .clk         (clk),
        .reset       (reset),
        .i_in_valid  (umi_in.valid),
        .o_in_ready  (umi_in.ready),
        .i_in_data   (w_skid_in),
        .o_out_valid (umi_out.valid),
        .i_out_ready (umi_out.ready),
        .o_out_data  (w_skid_out)
    );

    assign {w_out_meta, w_out_cmd, umi_out.dstaddr, umi_out.srcaddr, umi_out.data} = w_skid_out;
    assign umi_out.cmd = w_out_cmd;

    assign out_opcode      = w_out_cmd[OPCODE_LSB +: OPCODE_W];
    assign out_size        = w_out_cmd[SIZE_LSB +: SIZE_W];
    assign out_len         = w_out_cmd[LEN_LSB +: LEN_W];
    assign out_qos         = w_out_cmd[QOS_LSB +: QOS_W];
    assign out_prot        = w_out_cmd[PROT_LSB +: PROT_W];
    assign out_eom         = w_out_cmd[EOM_BIT];
    assign out_eof         = w_out_cmd[EOF_BIT];
    assign out_ex          = w_out_cmd[EX_BIT];
    assign out_hostid      = w_out_cmd[HOSTID_LSB +: HOSTID_W];
    assign out_user        = w_out_meta.user;
    assign out_err         = w_out_meta.err;
    assign out_request     = w_out_meta.request;
    assign out_response    = w_out_meta.response;
    assign out_invalid     = w_out_meta.invalid;
    assign out_error       = w_out_meta.error;
    assign out_link        = w_out_meta.link;
    assign out_link_resp   = w_out_meta.link_resp;
    assign out_bytes       = w_out_meta.bytes;
    assign out_som         = w_out_meta.som;
    assign out_beat        = w_out_meta.beat;
    assign out_mismatch    = w_out_meta.mismatch;
    assign sticky_mismatch = r_sticky_mismatch;
    assign sticky_invalid  = r_sticky_invalid;

`ifdef UMI_UNPACK_STATS_EN
    logic        w_out_fire;
    logic [15:0] r_stat_req;
    logic [15:0] r_stat_resp;
    logic [15:0] r_stat_err;

    assign w_out_fire = umi_out.valid && umi_out.ready;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_stat_req  <= '0;
            r_stat_resp <= '0;
            r_stat_err  <= '0;
        end else if (w_out_fire) begin
            if (w_out_meta.request && r_stat_req != 16'hFFFF)   r_stat_req  <= r_stat_req + 16'd1;
            if (w_out_meta.response && r_stat_resp != 16'hFFFF) r_stat_resp <= r_stat_resp + 16'd1;
            if (w_out_meta.error && r_stat_err != 16'hFFFF)     r_stat_err  <= r_stat_err + 16'd1;
        end
    end

    assign stat_req  = r_stat_req;
    assign stat_resp = r_stat_resp;
    assign stat_err  = r_stat_err;
`endif
endmodule

// File: doc/umi_unpack_pipe.md
Name: umi_unpack_pipe

Overview:
- Registered, flow-controlled UMI command unpacker.
- Accepts full UMI transactions (cmd/dstaddr/srcaddr/data) on a valid/ready port and forwards them unchanged through a 2-entry skid buffer.
- Each forwarded transaction carries pre-decoded command fields, class flags, a byte count and multi-beat message tracking (start-of-message, beat index, consistency check).
- Sits between a UMI port and endpoint/crossbar logic so downstream blocks never decode commands combinationally.

Parameters:
- CW, 32, command width; bits above 31 are passed through and not decoded.
- AW, 64, address width (dstaddr/srcaddr).
- DW, 256, data width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous clear of sticky status and of the message tracker.
- umi_in_valid  in  1  input valid.
- umi_in_cmd  in  CW  input command.
- umi_in_dstaddr  in  AW  input destination address.
- umi_in_srcaddr  in  AW  input source address.
- umi_in_data  in  DW  input data.
- umi_in_ready  out  1  input ready; registered.
- umi_out_valid  out  1  output valid.
- umi_out_ready  in  1  output ready.
- umi_out_cmd / umi_out_dstaddr / umi_out_srcaddr / umi_out_data  out  CW/AW/AW/DW  forwarded transaction.
- out_opcode[4:0], out_size[2:0], out_len[7:0], out_qos[3:0], out_prot[1:0], out_eom, out_eof, out_ex, out_hostid[4:0]  out  —  raw fields from cmd[4:0],[7:5],[15:8],[19:16],[21:20],22,23,24,[31:27].
- out_user  out  19  class-dependent user field.
- out_err  out  2  error code.
- out_request, out_response, out_invalid, out_error, out_link, out_link_resp  out  1 each  class flags.
- out_bytes  out  16  bytes carried by this beat.
- out_som  out  1  first beat of a message.
- out_beat  out  8  beat index within the message, saturating at 255.
- out_mismatch  out  1  opcode or hostid differs from the first beat of the same message.
- sticky_mismatch, sticky_invalid  out  1 each  sticky status flags.

Behaviour:
- Classification:
  - invalid = opcode==0x00.
  - request = opcode[0].
  - response = !opcode[0] && !invalid.
  - error = opcode==0x0F && size==0.
  - link = opcode==0x0F && size==1.
  - link_resp = opcode==0x0E.
  - error and link are also requests.
- out_user is selected in priority order:
  1. link: cmd[26:8]
  2. link_resp: {2'b0, cmd[24:8]}
  3. error: {8'h0, cmd[24:22], cmd[15:8]}
  4. request: {17'h0, cmd[26:25]}
  5. otherwise: 0
- out_err = cmd[26:25] when response or error, else 0.
- out_bytes = (len+1) << size, computed at 16 bits with no overflow (max 256*128 = 32768). It is 0 when invalid, error, link or link_resp.
- Handshake:
  - A transfer occurs when valid && ready on either side.
  - umi_in_ready = !skid_full, registered.
  - Full throughput: one beat per cycle when umi_out_ready is held high.
  - Latency is 1 cycle: a beat accepted in cycle N is presented in cycle N+1 when the output register is free.
  - Output payload and fields are stable while umi_out_valid && !umi_out_ready.
  - Ordering is preserved; no beat is dropped or duplicated.
- Skid buffer:
  - Output register plus one skid entry.
  - When umi_out_ready falls, the in-flight beat lands in skid and umi_in_ready drops next cycle.
  - Skid drains first when ready returns.
- Tracker FSM, states IDLE and MSG; it advances on input acceptance and its results travel with the beat:
  - IDLE: accepted beat gets som=1 and beat=0; opcode/hostid are latched. Goes to MSG if eom==0, stays IDLE if eom==1.
  - MSG: som=0, beat = previous+1 (saturating); mismatch=1 if opcode or hostid differs from the latched values. Returns to IDLE on eom==1.
  - Invalid beats bypass the tracker: state unchanged, som=0, beat=0, mismatch=0; they set sticky_invalid.
- Sticky flags:
  - sticky_mismatch is set on acceptance of a mismatch beat.
  - clear and reset zero both sticky flags and force the tracker to IDLE.
  - If clear and a set event coincide, the set wins.
- Reset:
  - Outputs umi_out_valid=0, umi_in_ready=0 during reset, then 1 the cycle after reset deasserts.
  - All field outputs and sticky flags are 0; tracker is IDLE.
  - Reset mid-message discards any buffered beats.

Optional Feature:
- UMI_UNPACK_STATS_EN defined:
  - Adds outputs stat_req[15:0], stat_resp[15:0] and stat_err[15:0].
  - Counters increment on output transfer of request, response and error beats respectively.
  - Counters saturate at 0xFFFF and are zeroed by reset or clear.
- UMI_UNPACK_STATS_EN undefined: those ports and counters do not exist.

Decomposition:
- Package umi_pkg holds:
  - opcode constants (UMI_INVALID, UMI_REQ_ERROR=0x0F, UMI_RESP_LINK=0x0E, ...);
  - field bit offsets and widths;
  - the tracker state enum.
- Sub-module umi_skid (parameter W) implements the 2-entry buffer over the concatenated payload and fields.
- Classification, user/err selection and the tracker stay in umi_unpack_pipe.

Test Plan:
- Single-beat write, cmd=0x0040_0303 (opcode 0x03, size 0, len 3, eom 1), umi_out_ready=1 -> one cycle later: out_request=1, out_bytes=4, out_som=1, out_beat=0, out_user=0.
- 3-beat read response (opcode 0x02, hostid 5, eom only on beat 3), sent back-to-back -> out_som=1,0,0; out_beat=0,1,2; out_mismatch=0; tracker IDLE after.
- 2-beat message where beat 2 has hostid 6 instead of 5 -> beat 2 has out_mismatch=1; sticky_mismatch=1 until clear pulses.
- Link request cmd=0x07FF_FF2F -> out_link=1, out_user=0x7FFFF, out_bytes=0, out_err=0.
- Random umi_out_ready toggling over 1000 beats -> output sequence matches input exactly, no drops; umi_in_ready is low only while skid is full.
- Assert reset during a 4-beat message after beat 2 -> umi_out_valid=0, tracker IDLE; the next beat is reported with out_som=1.
